// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared state encoding and select-width helper for the round-robin mux arbiter.
package rr_arb_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux_nx1.sv
// mux_nx1: combinational N:1 word select from a packed requester data bus.
module mux_nx1
    import rr_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SEL_W = sel_w(N)
) (
    input  logic [N*W-1:0]   data_in,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]     data_out
);

    always_comb begin
        data_out = data_in[W-1:0];
        for (int i = 1; i < N; i++)
            if (sel == SEL_W'(i)) data_out = data_in[i*W +: W];
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter sharing one N:1 mux, with a per-grant
// transfer limit and a dead IDLE cycle between consecutive grants.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    parameter int MAX_HOLD = 4,
    localparam int SEL_W = sel_w(N),
    localparam int CNT_W = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   data_in,
    input  logic             out_ready,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] sel,
    output logic [W-1:0]     data_out,
    output logic             out_valid,
    output logic             busy
);

    state_t           state;
    logic [SEL_W-1:0] ptr, pick, nxt;
    logic [SEL_W:0]   sum;
    logic [CNT_W-1:0] hold_cnt;
    logic             xfer, release_now;

    // Scan from the farthest offset down so the nearest requester at or after ptr wins.
    always_comb begin
        pick = ptr;
        sum  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (SEL_W+1)'(k);
            if (sum >= (SEL_W+1)'(N)) sum = sum - (SEL_W+1)'(N);
            if (req[sum[SEL_W-1:0]]) pick = sum[SEL_W-1:0];
        end
    end

    assign busy        = state == GRANT;
    assign out_valid   = busy & req[sel];
    assign xfer        = out_valid & out_ready;
    assign nxt         = (sel == SEL_W'(N - 1)) ? '0 : sel + SEL_W'(1);
    assign release_now = !req[sel] || (xfer && hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            if (|req) begin
                state    <= GRANT;
                gnt      <= N'(1) << pick;
                sel      <= pick;
                hold_cnt <= '0;
            end
        end else if (release_now) begin
            state    <= IDLE;
            gnt      <= '0;
            ptr      <= nxt;
            hold_cnt <= '0;
        end else if (xfer) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

    mux_nx1 #(.N(N), .W(W)) u_mux (
        .data_in (data_in),
        .sel     (sel),
        .data_out(data_out)
    );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: randomized and directed stimulus against a behavioural
// arbitration model; transfers are checked through a scoreboard queue.
module tb_rr_mux_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic           out_ready;
    logic [N-1:0]   gnt;
    logic [1:0]     sel;
    logic [W-1:0]   data_out;
    logic           out_valid;
    logic           busy;

    rr_mux_arbiter #(.N(N), .W(W), .MAX_HOLD(MH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data_in  (data_in),
        .out_ready(out_ready),
        .gnt      (gnt),
        .sel      (sel),
        .data_out (data_out),
        .out_valid(out_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           idx;
        logic [W-1:0] d;
    } xfer_t;

    xfer_t sbq[$];
    int    errors = 0;
    int    checks = 0;
    int    owner  = -1;
    int    turn   = 0;
    int    used   = 0;
    int    last   = 0;
    bit    rand_data = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        turn  = 0;
        used  = 0;
        last  = 0;
        sbq.delete();
    endtask

    // One cycle: drive at negedge, check current grant view, predict transfer and next grant.
    task automatic step(input logic [N-1:0] r, input logic rdy);
        bit moved;
        @(negedge clk);
        req       = r;
        out_ready = rdy;
        if (rand_data)
            for (int i = 0; i < N; i++) data_in[i*W +: W] = W'($urandom);
        #1;
        check("gnt", gnt, (owner < 0) ? 0 : (1 << owner));
        check("busy", busy, owner >= 0);
        check("sel", sel, last);
        check("out_valid", out_valid, (owner >= 0) && r[owner]);
        if (owner < 0) begin
            if (r != 0) begin
                moved = 1'b0;
                for (int k = 0; k < N; k++)
                    if (!moved && r[(turn + k) % N]) begin
                        owner = (turn + k) % N;
                        moved = 1'b1;
                    end
                last = owner;
                used = 0;
            end
        end else if (!r[owner]) begin
            turn  = (owner + 1) % N;
            owner = -1;
        end else if (rdy) begin
            sbq.push_back('{owner, data_in[owner*W +: W]});
            used++;
            if (used == MH) begin
                turn  = (owner + 1) % N;
                owner = -1;
            end
        end
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_extra: got transfer from sel %0d expected none at %0t", sel, $time);
                end else begin
                    xfer_t e;
                    e = sbq.pop_front();
                    check("xfer_sel", sel, e.idx);
                    check("xfer_data", data_out, e.d);
                end
            end else if (sbq.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL xfer_missing: got no transfer expected from %0d at %0t", sbq[0].idx, $time);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        data_in   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_data_out", data_out, data_in[W-1:0]);

        // Asynchronous reset in the middle of a grant to requester 2.
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_gnt", gnt, 0);
        check("async_busy", busy, 0);
        check("async_valid", out_valid, 0);
        check("async_sel", sel, 0);
        model_reset();
        @(negedge clk);
        req = '0;
        rst = 1'b0;
        step(4'b0001, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b0);

        // Full rotation with every requester active.
        hard_reset();
        repeat (22) step(4'b1111, 1'b1);

        // Hold limit on a single requester with a fixed data word.
        hard_reset();
        rand_data = 1'b0;
        data_in   = 32'h3C_5A_A5_0F;
        repeat (12) step(4'b0010, 1'b1);
        rand_data = 1'b1;

        // Backpressure then release.
        hard_reset();
        repeat (6) step(4'b1000, 1'b0);
        repeat (6) step(4'b1000, 1'b1);

        // Withdraw while stalled, others pending.
        hard_reset();
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b1011, 1'b0);
        repeat (12) step(4'b1011, 1'b1);

        // Pointer wrap from 3.
        hard_reset();
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        repeat (12) step(4'b0101, 1'b1);

        // Random traffic: request patterns held for a few cycles, random backpressure.
        hard_reset();
        for (int b = 0; b < 120; b++) begin
            logic [N-1:0] r;
            r = N'($urandom);
            repeat ($urandom_range(1, 6)) step(r, 1'(($urandom % 4) != 0));
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        @(negedge clk);
        #3;
        check("sbq_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
